mesh_out_arbiter: RTL
=====================

# mesh_out_arbiter

Per-output-port switch allocator for the 2x2 mesh router. Shares one router output port among up to N_IN requesting input ports (N/E/S/W/local) using round-robin arbitration. It buffers granted flits in a small output FIFO and presents them downstream on the same req/ack flit handshake used at the mesh ports. Each router instantiates one per output direction.

## Interface

Parameters:
- N_IN, 5, number of competing input ports (2..8)
- FLIT_LENGTH, `FLIT_LENGTH` from define.vh, flit width in bits
- DEPTH, 2, output FIFO entries (power of two, 2..8)

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- in_req  input  N_IN  per-input request; flit valid on in_data slice
- in_data  input  N_IN*FLIT_LENGTH  packed flits; input i at [i*FLIT_LENGTH +: FLIT_LENGTH]
- in_ack  output  N_IN  one-hot grant; flit of granted input is captured at next rising edge
- out_req  output  1  FIFO non-empty; out_data valid
- out_data  output  FLIT_LENGTH  head flit; 0 when FIFO empty
- out_ack  input  1  downstream accepts head flit at next rising edge
- grant_id  output  3  index of last granted input (registered)
- stall_cnt  output  16  saturating count of cycles with out_req=1 and out_ack=0

## Operation

- State: FIFO storage DEPTH x FLIT_LENGTH, wr_ptr, rd_ptr, count (0..DEPTH), rr_ptr (0..N_IN-1), grant_id, stall_cnt.
- Reset (rst=0, async): count=0, wr_ptr=rd_ptr=0, rr_ptr=0, grant_id=0, stall_cnt=0; hence out_req=0, out_data=0, in_ack=0. FIFO storage contents are don't-care.
- Arbitration (combinational):
  - space = (count < DEPTH).
  - Winner = first i with in_req[i]=1, scanning cyclically from rr_ptr upward (rr_ptr, rr_ptr+1, ..., N_IN-1, 0, ...).
  - in_ack = onehot(winner) if space and any in_req, else 0.
  - At most one in_ack bit high per cycle.
- Push: on edge with |in_ack, write in_data[winner] at wr_ptr; wr_ptr+1 mod DEPTH; rr_ptr <= (winner+1) mod N_IN; grant_id <= winner.
- No grant: rr_ptr and grant_id hold.
- Pop: on edge with out_req & out_ack, rd_ptr+1 mod DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
- Full (count=DEPTH): in_ack=0 even if out_ack=1 this cycle. No pop-through; a freed slot is usable the following cycle.
- Empty (count=0): out_req=0, out_data=0; out_ack ignored.
- stall_cnt: +1 on each edge with out_req=1 and out_ack=0; saturates at 16'hFFFF; never wraps.
- Requester dropping in_req without grant: legal; no state change.
- Flit content is opaque; no field is interpreted.

## Timing

- in_ack depends combinationally on in_req, count and rr_ptr only. No path from out_ack to in_ack or to out_req.
- out_req and out_data come from registers/FIFO head only.
- Latency: flit granted at edge k gives out_req=1 and out_data=flit after edge k (one cycle) if FIFO was empty.
- Throughput: one flit/cycle sustained when out_ack held high and DEPTH>=2.
- Reset asserted mid-transfer: all state clears immediately (async). Buffered flits are dropped. in_ack and out_req fall without waiting for a clock.
- Reset deassertion is synchronised externally; the block may grant on the first edge after release.

## Test plan

- Reset: hold rst=0 with in_req=5'b11111 -> in_ack=0, out_req=0, out_data=0, stall_cnt=0, grant_id=0. Release -> first edge grants input 0.
- Round-robin fairness: in_req=5'b11111 constant, out_ack=1, in_data[i]=i+1 -> grant order 0,1,2,3,4,0,...; out_data sequence 1,2,3,4,5,1 starting one cycle after first grant.
- Skip idle inputs: rr_ptr=2, in_req=5'b00011 -> grant input 0, then rr_ptr=1 -> next grant input 1.
- Full/backpressure: DEPTH=2, out_ack=0, in_req[3]=1 -> two grants on consecutive edges, then in_ack=0. stall_cnt increments each cycle. Raise out_ack for one cycle -> pop 1, in_ack[3]=1 only on the following cycle, and flits exit in FIFO order.
- Simultaneous push/pop at count=1: in_req[1]=1, out_ack=1 -> count stays 1, out_data advances to the new flit.
- stall_cnt saturation: out_req=1, out_ack=0 for 70000 cycles -> stall_cnt=16'hFFFF and held. Async reset mid-stall -> 0 immediately.

Source files
------------

// File: rtl/mesh_out_arbiter.sv
// rtl/mesh_out_arbiter.sv - round-robin output-port allocator with small flit FIFO for the 2x2 mesh router
`ifndef FLIT_LENGTH
`define FLIT_LENGTH 32
`endif

module mesh_out_arbiter #(
    parameter int N_IN        = 5,
    parameter int FLIT_LENGTH = `FLIT_LENGTH,
    parameter int DEPTH       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_IN-1:0]               in_req,
    input  logic [N_IN*FLIT_LENGTH-1:0]   in_data,
    output logic [N_IN-1:0]               in_ack,
    output logic                          out_req,
    output logic [FLIT_LENGTH-1:0]        out_data,
    input  logic                          out_ack,
    output logic [2:0]                    grant_id,
    output logic [15:0]                   stall_cnt
);

    localparam int IW = $clog2(N_IN);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [FLIT_LENGTH-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [IW-1:0]          rr_ptr;

    logic [IW-1:0]          winner;
    logic                   found;
    logic [IW:0]            scan_idx;
    logic [FLIT_LENGTH-1:0] win_flit;
    logic                   space;
    logic                   push;
    logic                   pop;

    // Scan cyclically from rr_ptr; the first requester found wins.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < N_IN; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(N_IN)) begin
                scan_idx = scan_idx - (IW+1)'(N_IN);
            end
            if (!found && in_req[scan_idx[IW-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        win_flit = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (winner == IW'(i)) begin
                win_flit = in_data[i*FLIT_LENGTH +: FLIT_LENGTH];
            end
        end
    end

    // Grants only while a slot is free now; a slot freed by this cycle's pop is not reused.
    assign space  = (count < CW'(DEPTH));
    assign in_ack = (rst && space && found) ? (N_IN'(1) << winner) : '0;
    assign push   = |in_ack;

    assign out_req  = (count != '0);
    assign out_data = out_req ? mem[rd_ptr] : '0;
    assign pop      = out_req && out_ack;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= win_flit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rr_ptr    <= '0;
            grant_id  <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                rr_ptr   <= (winner == IW'(N_IN - 1)) ? '0 : winner + IW'(1);
                grant_id <= 3'(winner);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (out_req && !out_ack && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule
